// File: rtl/regfile_wb_arbiter_if.sv
// Purpose: bundles the issue, ALU writeback, LSU writeback and register-file write
//          signals of the writeback arbiter into one bus.
// Ports:   issue_* (decode side), alu_* (execute side), lsu_* (load/store unit side),
//          rf_* (register file write port). The slave modport is the arbiter; the master is its environment.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            issue_valid;
  logic [4:0]      issue_rs1;
  logic [4:0]      issue_rs2;
  logic [4:0]      issue_rd;
  logic            issue_load;
  logic            issue_stall;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_stall;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;

  logic            rf_en;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_load,
    output issue_stall,
    input  alu_valid, alu_rd, alu_data,
    output alu_stall,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output rf_en, rf_rd, rf_data
  );

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_load,
    input  issue_stall,
    output alu_valid, alu_rd, alu_data,
    input  alu_stall,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  rf_en, rf_rd, rf_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register-file write port between ALU and LSU writeback, with an LSU
//          skid FIFO, ALU priority plus starvation guard, and a load scoreboard for issue.
// Latency: the winning write appears on rf_* one cycle after the grant.
// Backpressure: alu_stall when a forced FIFO drain preempts the ALU. lsu_ready drops when the
//          FIFO is full. issue_stall on a RAW/WAW hit against an outstanding load.
// Ports:   clk, rst (sync, active-high). bus is the slave modport of regfile_wb_arbiter_if.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {WIN_NONE, WIN_ALU, WIN_FIFO, WIN_LSU} win_e;

  logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [31:0]     pending_q, pending_d;
  logic            rf_en_q, rf_en_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;

  win_e            win;
  logic            fifo_ne, force_fifo, lsu_rdy, lsu_xfer, push, pop, issue_hit;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    fifo_ne    = (count_q != '0);
    force_fifo = (starve_q == SW'(STARVE_LIMIT)) && fifo_ne;
    // Readiness looks only at the registered count, so it never depends on this cycle's pop.
    lsu_rdy    = (count_q < CW'(FIFO_DEPTH));
    lsu_xfer   = bus.lsu_valid && lsu_rdy;

    if (force_fifo)         win = WIN_FIFO;
    else if (bus.alu_valid) win = WIN_ALU;
    else if (fifo_ne)       win = WIN_FIFO;
    else if (lsu_xfer)      win = WIN_LSU;   // empty FIFO: load data bypasses storage
    else                    win = WIN_NONE;

    win_rd   = '0;
    win_data = '0;
    case (win)
      WIN_ALU:  begin win_rd = bus.alu_rd;        win_data = bus.alu_data;        end
      WIN_FIFO: begin win_rd = fifo_rd_q[head_q]; win_data = fifo_data_q[head_q]; end
      WIN_LSU:  begin win_rd = bus.lsu_rd;        win_data = bus.lsu_data;        end
      default:  ;
    endcase

    push   = lsu_xfer && (win != WIN_LSU);
    pop    = (win == WIN_FIFO);
    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);

    // A FIFO win (forced or not) or an empty FIFO restarts the starvation window.
    starve_d = starve_q;
    if (pop || !fifo_ne)     starve_d = '0;
    else if (win == WIN_ALU) starve_d = starve_q + SW'(1);

    issue_hit = pending_q[bus.issue_rs1] | pending_q[bus.issue_rs2] | pending_q[bus.issue_rd];

    // Clear first, then set, so a same-edge set of the same rd wins.
    pending_d = pending_q;
    if (win == WIN_FIFO || win == WIN_LSU) pending_d[win_rd] = 1'b0;
    if (bus.issue_valid && !issue_hit && bus.issue_load) pending_d[bus.issue_rd] = 1'b1;
    pending_d[0] = 1'b0;

    rf_en_d   = (win != WIN_NONE) && (win_rd != '0);
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (win != WIN_NONE) begin
      rf_rd_d   = win_rd;
      rf_data_d = win_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      pending_q <= '0;
      rf_en_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      rf_en_q   <= rf_en_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[tail_q]   <= bus.lsu_rd;
      fifo_data_q[tail_q] <= bus.lsu_data;
    end
  end

  assign bus.issue_stall = bus.issue_valid && issue_hit;
  assign bus.alu_stall   = bus.alu_valid && force_fifo;
  assign bus.lsu_ready   = lsu_rdy;
  assign bus.rf_en       = rf_en_q;
  assign bus.rf_rd       = rf_rd_q;
  assign bus.rf_data     = rf_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, scoreboard as a bit array, plain priority rules.
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] d;
  } ent_t;

  ent_t            mq[$];
  bit              m_pend [32];
  int              m_starve = 0;
  logic            m_en = 1'b0;
  logic [4:0]      m_rd = '0;
  logic [XLEN-1:0] m_data = '0;
  bit              m_known = 1'b1;   // rf_rd/rf_data are only predicted after a real write or reset

  always @(negedge clk) begin : model
    int              win;
    bit              fe, lready, forced, istall;
    logic [4:0]      wr;
    logic [XLEN-1:0] wd;
    ent_t            e;

    chk("rf_en", 32'(bus.rf_en), 32'(m_en));
    if (m_known) begin
      chk("rf_rd", 32'(bus.rf_rd), 32'(m_rd));
      chk("rf_data", bus.rf_data, m_data);
    end

    fe     = (mq.size() != 0);
    lready = (mq.size() < DEPTH);
    forced = (m_starve == LIMIT) && fe;
    istall = bus.issue_valid &&
             (m_pend[bus.issue_rs1] || m_pend[bus.issue_rs2] || m_pend[bus.issue_rd]);
    if (forced)                        win = 2;
    else if (bus.alu_valid)            win = 1;
    else if (fe)                       win = 2;
    else if (bus.lsu_valid && lready)  win = 3;
    else                               win = 0;

    chk("lsu_ready", 32'(bus.lsu_ready), 32'(lready));
    chk("alu_stall", 32'(bus.alu_stall), 32'(bus.alu_valid && win != 1));
    chk("issue_stall", 32'(bus.issue_stall), 32'(istall));

    if (rst) begin
      mq.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_starve = 0;
      m_en = 1'b0; m_rd = '0; m_data = '0; m_known = 1'b1;
    end else begin
      wr = '0; wd = '0;
      if (win == 1) begin wr = bus.alu_rd; wd = bus.alu_data; end
      if (win == 2) begin e = mq.pop_front(); wr = e.rd; wd = e.d; m_pend[wr] = 1'b0; end
      if (win == 3) begin wr = bus.lsu_rd; wd = bus.lsu_data; m_pend[wr] = 1'b0; end
      if (bus.lsu_valid && lready && win != 3) mq.push_back('{rd: bus.lsu_rd, d: bus.lsu_data});
      if (win == 2 || !fe) m_starve = 0;
      else if (win == 1)   m_starve++;
      if (bus.issue_valid && !istall && bus.issue_load && bus.issue_rd != 0)
        m_pend[bus.issue_rd] = 1'b1;
      m_en = (win != 0) && (wr != 0);
      if (win != 0) begin
        if (wr != 0) begin m_known = 1'b1; m_rd = wr; m_data = wd; end
        else m_known = 1'b0;   // rd==0 grant: address/data lines left unspecified
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    bus.issue_rd = '0; bus.issue_load = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid = v; bus.lsu_rd = rd; bus.lsu_data = d;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic ld);
    bus.issue_valid = v; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
    bus.issue_rd = rd; bus.issue_load = ld;
  endtask

  initial begin : stim
    logic s_astall, s_lready;
    idle();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset rf_en", 32'(bus.rf_en), 32'd0);
    chk("reset rf_rd", 32'(bus.rf_rd), 32'd0);
    chk("reset rf_data", bus.rf_data, 32'd0);
    chk("reset lsu_ready", 32'(bus.lsu_ready), 32'd1);
    chk("reset alu_stall", 32'(bus.alu_stall), 32'd0);
    chk("reset issue_stall", 32'(bus.issue_stall), 32'd0);

    // ALU write lands one cycle after grant
    step(); alu(1, 5, 32'h11);
    step(); alu(0, 0, 0);
    @(negedge clk);
    chk("alu rf_en", 32'(bus.rf_en), 32'd1);
    chk("alu rf_rd", 32'(bus.rf_rd), 32'd5);
    chk("alu rf_data", bus.rf_data, 32'h11);

    // load to x7, dependent issue stalls until the load data is latched
    step(); issue(1, 0, 0, 7, 1);
    step(); issue(1, 7, 0, 1, 0);
    @(negedge clk); chk("raw stall", 32'(bus.issue_stall), 32'd1);
    step(); lsu(1, 7, 32'hABCD);
    @(negedge clk); chk("raw stall held", 32'(bus.issue_stall), 32'd1);
    step(); lsu(0, 0, 0);
    @(negedge clk);
    chk("load rf_en", 32'(bus.rf_en), 32'd1);
    chk("load rf_rd", 32'(bus.rf_rd), 32'd7);
    chk("load rf_data", bus.rf_data, 32'hABCD);
    chk("raw stall released", 32'(bus.issue_stall), 32'd0);
    step(); idle();

    // simultaneous ALU and LSU: ALU first, LSU from FIFO next
    alu(1, 9, 32'h99); lsu(1, 10, 32'h1010);
    step(); idle();
    @(negedge clk); chk("both alu first", 32'(bus.rf_rd), 32'd9);
    step();
    @(negedge clk);
    chk("both lsu second", 32'(bus.rf_rd), 32'd10);
    chk("both lsu data", bus.rf_data, 32'h1010);

    // FIFO fill and starvation guard
    step(); alu(1, 11, 32'hA0); lsu(1, 20, 32'h2020);
    step(); alu(1, 12, 32'hA1); lsu(1, 21, 32'h2121);
    step(); alu(1, 13, 32'hA2); lsu(1, 22, 32'h2222);
    @(negedge clk); chk("fifo full ready", 32'(bus.lsu_ready), 32'd0);
    step(); alu(1, 14, 32'hA3); lsu(0, 0, 0);
    step(); alu(1, 15, 32'hA4);
    @(negedge clk); chk("starve not yet", 32'(bus.alu_stall), 32'd0);
    step(); alu(1, 16, 32'hA5);
    @(negedge clk); chk("starve forced", 32'(bus.alu_stall), 32'd1);
    step();
    @(negedge clk);
    chk("forced rf_rd", 32'(bus.rf_rd), 32'd20);
    chk("forced rf_data", bus.rf_data, 32'h2020);
    chk("alu resumes", 32'(bus.alu_stall), 32'd0);
    step(); alu(0, 0, 0);
    @(negedge clk); chk("held alu written", 32'(bus.rf_rd), 32'd16);
    step();
    @(negedge clk);
    chk("drain rf_rd", 32'(bus.rf_rd), 32'd21);
    chk("drain rf_data", bus.rf_data, 32'h2121);

    // rd==0 writes and loads are discarded
    step(); alu(1, 0, 32'hFFFF);
    step(); alu(0, 0, 0); issue(1, 0, 0, 0, 1);
    @(negedge clk); chk("x0 write dropped", 32'(bus.rf_en), 32'd0);
    step(); issue(1, 0, 0, 0, 0);
    @(negedge clk); chk("x0 load no stall", 32'(bus.issue_stall), 32'd0);
    step(); idle();

    // reset with FIFO full and x3 pending
    issue(1, 0, 0, 3, 1); alu(1, 12, 32'h1); lsu(1, 30, 32'h3);
    step(); issue(1, 3, 0, 5, 0); alu(1, 13, 32'h2); lsu(1, 31, 32'h4);
    @(negedge clk); chk("x3 pending", 32'(bus.issue_stall), 32'd1);
    step(); idle(); rst = 1'b1;
    @(negedge clk); chk("pre-reset full", 32'(bus.lsu_ready), 32'd0);
    step(); rst = 1'b0; issue(1, 3, 0, 4, 0);
    @(negedge clk);
    chk("post-reset ready", 32'(bus.lsu_ready), 32'd1);
    chk("post-reset no stall", 32'(bus.issue_stall), 32'd0);
    chk("post-reset rf_en", 32'(bus.rf_en), 32'd0);
    s_astall = bus.alu_stall;
    s_lready = bus.lsu_ready;

    // randomized traffic, execute and LSU honour their hold rules
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!(bus.alu_valid && s_astall))
        alu(logic'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom);
      if (!(bus.lsu_valid && !s_lready))
        lsu(logic'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom);
      issue(logic'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), logic'($urandom_range(0, 99) < 40));
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      s_astall = bus.alu_stall;
      s_lready = bus.lsu_ready;
    end

    step(); idle(); rst = 1'b0;
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
